// File: rtl/vdda_seq_pkg.sv
// Shared types for the VDDA/VSWITCH supply sequencer: FSM state encoding,
// the packed output vector and the per-state output decode.
package vdda_seq_pkg;

  typedef enum logic [2:0] {
    OFF,
    BIAS,
    PLL_ON,
    RELEASE,
    READY,
    FAULT
  } seq_state_t;

  typedef struct packed {
    logic bias_en;
    logic pll_en;
    logic iso_n;
    logic amux_connect;
    logic ready;
    logic fault;
  } seq_outs_t;

  localparam seq_outs_t OUTS_OFF     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam seq_outs_t OUTS_BIAS    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam seq_outs_t OUTS_PLL_ON  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam seq_outs_t OUTS_RELEASE = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam seq_outs_t OUTS_READY   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam seq_outs_t OUTS_FAULT   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // Output vector driven while the FSM sits in a given state.
  function automatic seq_outs_t state_outs(input seq_state_t s);
    case (s)
      BIAS:    return OUTS_BIAS;
      PLL_ON:  return OUTS_PLL_ON;
      RELEASE: return OUTS_RELEASE;
      READY:   return OUTS_READY;
      FAULT:   return OUTS_FAULT;
      default: return OUTS_OFF;
    endcase
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/supply_debounce.sv
// Synchroniser plus slow-on / fast-off debounce for one raw supply-good flag.
// Ports:
//   clk, resetb : clock, asynchronous active-low reset
//   raw_i       : comparator flag, asynchronous to clk
//   filt_o      : debounced flag; rises after DEB_CYCLES consecutive synced-1
//                 samples, falls on the edge after any synced-0 sample
module supply_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 1024
) (
  input  logic clk,
  input  logic resetb,
  input  logic raw_i,
  output logic filt_o
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [DW-1:0]          cnt_q;
  logic [DW-1:0]          cnt_d;
  logic                   filt_q;
  logic                   filt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Shift chain plus saturating run-length counter of synced-1 samples.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d  = '0;
    filt_d = 1'b0;
    if (synced) begin
      cnt_d  = (cnt_q == DW'(DEB_CYCLES)) ? cnt_q : cnt_q + DW'(1);
      // This sample completes the run when DEB_CYCLES-1 ones were already seen.
      filt_d = (cnt_q >= DW'(DEB_CYCLES - 1));
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/vdda_supply_sequencer.sv
// Analog PLL domain power sequencer fed by the VDDA/VSWITCH supply-good flags.
// Sequence on en_req: bias -> PLL -> isolation release -> AMUX connect/ready.
// Brown-out drops every enable at once and latches fault until cleared.
// Ports:
//   clk, resetb              : clock, asynchronous active-low reset
//   vdda_ok_raw, vswitch_ok_raw : raw comparator flags (asynchronous)
//   en_req                   : level request to power the analog domain
//   fault_clr                : single-cycle pulse, clears latched fault
//   bias_en, pll_en, iso_n, amux_connect, ready, fault : registered controls
module vdda_supply_sequencer
  import vdda_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 1024,
  parameter int unsigned BIAS_SETTLE = 256,
  parameter int unsigned PLL_SETTLE  = 4096
) (
  input  logic clk,
  input  logic resetb,
  input  logic vdda_ok_raw,
  input  logic vswitch_ok_raw,
  input  logic en_req,
  input  logic fault_clr,
  output logic bias_en,
  output logic pll_en,
  output logic iso_n,
  output logic amux_connect,
  output logic ready,
  output logic fault
);

  localparam int unsigned CNT_MAX = max3(DEB_CYCLES, BIAS_SETTLE, PLL_SETTLE);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic       filt_vdda;
  logic       filt_vsw;
  logic       pwr_ok;
  seq_state_t state_q;
  seq_state_t state_d;
  logic [CNT_W-1:0] settle_q;
  logic [CNT_W-1:0] settle_d;
  seq_outs_t  outs_q;
  seq_outs_t  outs_d;

  supply_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_deb_vdda (
    .clk    (clk),
    .resetb (resetb),
    .raw_i  (vdda_ok_raw),
    .filt_o (filt_vdda)
  );

  supply_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_deb_vsw (
    .clk    (clk),
    .resetb (resetb),
    .raw_i  (vswitch_ok_raw),
    .filt_o (filt_vsw)
  );

  assign pwr_ok = filt_vdda & filt_vsw;

  // Next state, settle counter and outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF: begin
        if (en_req && pwr_ok && !outs_q.fault) state_d = BIAS;
      end
      BIAS, PLL_ON, RELEASE, READY: begin
        // Brown-out wins over a simultaneous power-down request.
        if (!pwr_ok) begin
          state_d = FAULT;
        end else if (!en_req) begin
          state_d = OFF;
        end else begin
          case (state_q)
            BIAS:    if (settle_q == CNT_W'(BIAS_SETTLE - 1)) state_d = PLL_ON;
            PLL_ON:  if (settle_q == CNT_W'(PLL_SETTLE - 1))  state_d = RELEASE;
            RELEASE: state_d = READY;
            default: state_d = state_q;
          endcase
        end
      end
      FAULT: begin
        if (fault_clr && !en_req) state_d = OFF;
      end
      default: state_d = OFF;
    endcase

    // Counter restarts on every state entry and saturates while parked.
    if (state_d != state_q) begin
      settle_d = '0;
    end else begin
      settle_d = (settle_q == CNT_W'(CNT_MAX)) ? settle_q : settle_q + CNT_W'(1);
    end

    outs_d = state_outs(state_d);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= OFF;
      settle_q <= '0;
      outs_q   <= OUTS_OFF;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      outs_q   <= outs_d;
    end
  end

  assign bias_en      = outs_q.bias_en;
  assign pll_en       = outs_q.pll_en;
  assign iso_n        = outs_q.iso_n;
  assign amux_connect = outs_q.amux_connect;
  assign ready        = outs_q.ready;
  assign fault        = outs_q.fault;

endmodule

// File: tb/tb_vdda_supply_sequencer.sv
// Bench for vdda_supply_sequencer: directed scenarios with literal expectations,
// then randomized flags/requests compared every cycle against a reference model.
module tb_vdda_supply_sequencer;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int BS   = 4;
  localparam int PS   = 6;

  localparam int PH_OFF  = 0;
  localparam int PH_BIAS = 1;
  localparam int PH_PLL  = 2;
  localparam int PH_REL  = 3;
  localparam int PH_RDY  = 4;
  localparam int PH_FLT  = 5;

  logic clk = 1'b0;
  logic resetb;
  logic vdda_ok_raw;
  logic vswitch_ok_raw;
  logic en_req;
  logic fault_clr;
  logic bias_en;
  logic pll_en;
  logic iso_n;
  logic amux_connect;
  logic ready;
  logic fault;

  always #5 clk = ~clk;

  vdda_supply_sequencer #(
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB),
    .BIAS_SETTLE (BS),
    .PLL_SETTLE  (PS)
  ) dut (
    .clk            (clk),
    .resetb         (resetb),
    .vdda_ok_raw    (vdda_ok_raw),
    .vswitch_ok_raw (vswitch_ok_raw),
    .en_req         (en_req),
    .fault_clr      (fault_clr),
    .bias_en        (bias_en),
    .pll_en         (pll_en),
    .iso_n          (iso_n),
    .amux_connect   (amux_connect),
    .ready          (ready),
    .fault          (fault)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: raw flag history per edge since reset, plus phase/entry edge.
  int e;
  bit qv[$];
  bit qs[$];
  int m_phase;
  int m_entry;
  bit m_pwr;

  int first_b;
  int first_p;
  int first_i;
  int first_r;

  function automatic logic [5:0] dut_outs();
    return {bias_en, pll_en, iso_n, amux_connect, ready, fault};
  endfunction

  // {bias, pll, iso_n, amux, ready, fault} expected for a model phase.
  function automatic logic [5:0] phase_outs(input int ph);
    logic [5:0] v;
    v[5] = (ph >= PH_BIAS && ph <= PH_RDY);
    v[4] = (ph >= PH_PLL && ph <= PH_RDY);
    v[3] = (ph == PH_REL || ph == PH_RDY);
    v[2] = (ph == PH_RDY);
    v[1] = (ph == PH_RDY);
    v[0] = (ph == PH_FLT);
    return v;
  endfunction

  // Power is good after edge n when both raw flags were 1 before each of the
  // DEB edges ending SYNC edges earlier.
  function automatic bit window_ok(input int n);
    if (n < SYNC + DEB) return 1'b0;
    for (int k = n - (SYNC + DEB) + 1; k <= n - SYNC; k++) begin
      if (!(qv[k-1] && qs[k-1])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    e = 0;
    qv.delete();
    qs.delete();
    m_phase = PH_OFF;
    m_entry = 0;
  endtask

  task automatic go(input int ph);
    m_phase = ph;
    m_entry = e;
  endtask

  task automatic model_step();
    m_pwr = window_ok(e);
    e = e + 1;
    qv.push_back(vdda_ok_raw);
    qs.push_back(vswitch_ok_raw);
    case (m_phase)
      PH_OFF: if (en_req && m_pwr) go(PH_BIAS);
      PH_FLT: if (fault_clr && !en_req) go(PH_OFF);
      default: begin
        if (!m_pwr) go(PH_FLT);
        else if (!en_req) go(PH_OFF);
        else if (m_phase == PH_BIAS && e - m_entry == BS) go(PH_PLL);
        else if (m_phase == PH_PLL && e - m_entry == PS) go(PH_REL);
        else if (m_phase == PH_REL && e - m_entry == 1) go(PH_RDY);
      end
    endcase
  endtask

  task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%b required=%b t=%0t", name, e, act, exp_v, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic clear_track();
    first_b = -1;
    first_p = -1;
    first_i = -1;
    first_r = -1;
  endtask

  // One clock: model advances at posedge, DUT compared against model at negedge.
  task automatic tick();
    @(posedge clk);
    if (resetb) model_step();
    @(negedge clk);
    check6("outputs_vs_model", dut_outs(), phase_outs(m_phase));
    if (bias_en && first_b < 0) first_b = e;
    if (pll_en && first_p < 0) first_p = e;
    if (iso_n && first_i < 0) first_i = e;
    if (ready && first_r < 0) first_r = e;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input bit v, input bit s, input bit en);
    resetb = 1'b0;
    model_reset();
    vdda_ok_raw = v;
    vswitch_ok_raw = s;
    en_req = en;
    fault_clr = 1'b0;
    @(negedge clk);
    check6("reset_outs", dut_outs(), 6'b000000);
    @(negedge clk);
    resetb = 1'b1;
    clear_track();
  endtask

  initial begin
    // Power-up sequence timing.
    do_reset(1'b1, 1'b1, 1'b1);
    ticks(30);
    checki("bias_first_edge", first_b, 11);
    checki("pll_first_edge", first_p, 15);
    checki("iso_first_edge", first_i, 21);
    checki("ready_first_edge", first_r, 22);

    // Brown-out from READY, then fault clearing rules.
    vswitch_ok_raw = 1'b0;
    ticks(3);
    check6("ready_before_brownout", dut_outs(), 6'b111110);
    tick();
    check6("brownout_fault", dut_outs(), 6'b000001);
    vswitch_ok_raw = 1'b1;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check6("clr_with_en_ignored", dut_outs(), 6'b000001);
    en_req = 1'b0;
    tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check6("clr_without_en", dut_outs(), 6'b000000);
    ticks(3);

    // Glitch at debounce count 5 restarts the run.
    do_reset(1'b1, 1'b1, 1'b1);
    ticks(5);
    vdda_ok_raw = 1'b0;
    tick();
    vdda_ok_raw = 1'b1;
    ticks(20);
    checki("bias_after_glitch", first_b, 17);

    // Power-down in PLL_ON, restart, then simultaneous brown-out / en_req drop.
    do_reset(1'b1, 1'b1, 1'b1);
    ticks(16);
    check6("in_pll_on", dut_outs(), 6'b110000);
    en_req = 1'b0;
    tick();
    check6("powerdown_outs", dut_outs(), 6'b000000);
    en_req = 1'b1;
    tick();
    check6("restart_bias", dut_outs(), 6'b100000);
    ticks(11);
    check6("ready_again", dut_outs(), 6'b111110);
    vdda_ok_raw = 1'b0;
    ticks(3);
    en_req = 1'b0;
    tick();
    check6("brownout_priority", dut_outs(), 6'b000001);
    vdda_ok_raw = 1'b1;
    ticks(2);

    // Asynchronous reset in PLL_ON.
    do_reset(1'b1, 1'b1, 1'b1);
    ticks(16);
    #2;
    resetb = 1'b0;
    model_reset();
    #1;
    check6("async_reset_outs", dut_outs(), 6'b000000);
    tick();
    resetb = 1'b1;
    clear_track();
    ticks(15);
    checki("bias_after_reset", first_b, 11);
    checki("no_fault_after_reset", int'(fault), 0);

    // Randomized flags, requests and clear pulses.
    do_reset(1'b1, 1'b1, 1'b0);
    for (int seg = 0; seg < 16; seg++) begin
      int rate;
      rate = 30 * int'($urandom_range(0, 3));
      if (seg % 4 == 0) rate = 0;
      for (int c = 0; c < 200; c++) begin
        vdda_ok_raw    = (int'($urandom_range(0, 999)) >= rate);
        vswitch_ok_raw = (int'($urandom_range(0, 999)) >= rate);
        if ($urandom_range(0, 49) == 0) en_req = ~en_req;
        fault_clr = ($urandom_range(0, 9) == 0);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
